// File: rtl/dma_s2m_writer.sv
// Stream-to-memory DMA writer: buffers AXI-Stream beats in a small FIFO and
// writes them as consecutive 32-bit words starting at a configured base address.
module dma_s2m_writer #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    // configuration / status
    input  logic        cfg_start,
    input  logic [31:0] cfg_base,
    input  logic [6:0]  cfg_len,
    output logic        busy,
    output logic        done,
    output logic        err_len,
    output logic [6:0]  wr_count,
    // stream slave
    input  logic        ss_tvalid,
    input  logic [31:0] ss_tdata,
    input  logic        ss_tlast,
    output logic        ss_tready,
    // memory write master
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack
);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW:0] FullCnt = (PW + 1)'(FIFO_DEPTH);
    localparam logic [PW:0] OneCnt  = (PW + 1)'(1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_t;

    state_t       state;
    logic [31:0]  base;
    logic [6:0]   len;
    logic [6:0]   acc_cnt;

    logic [31:0]  fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]  count;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic last_by_len;
    logic term_beat;
    logic drain_done;

    assign full  = (count == FullCnt);
    assign empty = (count == '0);

    assign ss_tready = (state == StRun) && !full && (acc_cnt < len);
    assign mem_req   = ((state == StRun) || (state == StDrain)) && !empty;
    assign mem_addr  = base + {23'd0, wr_count, 2'b00};
    // Gated so the bus reads zero out of reset instead of stale buffer contents.
    assign mem_wdata = empty ? 32'd0 : fifo_mem[rd_ptr];

    assign push = ss_tvalid && ss_tready;
    assign pop  = mem_req && mem_ack;

    assign last_by_len = (acc_cnt + 7'd1 == len);
    assign term_beat   = push && (ss_tlast || last_by_len);
    // Looks one cycle ahead so done follows the final ack by exactly one cycle.
    assign drain_done  = ((count == '0) || ((count == OneCnt) && pop)) &&
                         ((wr_count + {6'd0, pop}) == acc_cnt);

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + OneCnt;
                2'b01:   count <= count - OneCnt;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; no reset needed since reads are gated by empty.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= ss_tdata;
    end

    // Job FSM with counters, sticky length error and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= StIdle;
            base     <= 32'd0;
            len      <= 7'd0;
            acc_cnt  <= 7'd0;
            wr_count <= 7'd0;
            err_len  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (push) acc_cnt  <= acc_cnt + 7'd1;
            if (pop)  wr_count <= wr_count + 7'd1;
            unique case (state)
                StIdle: begin
                    if (cfg_start) begin
                        base     <= cfg_base;
                        len      <= cfg_len;
                        acc_cnt  <= 7'd0;
                        wr_count <= 7'd0;
                        err_len  <= 1'b0;
                        if (cfg_len == 7'd0) begin
                            state <= StDone;
                            done  <= 1'b1;
                        end else begin
                            state <= StRun;
                            busy  <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (term_beat) begin
                        state <= StDrain;
                        // Early tlast or missing tlast on the final beat.
                        if (ss_tlast != last_by_len) err_len <= 1'b1;
                    end
                end
                StDrain: begin
                    if (drain_done) begin
                        state <= StDone;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
